// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte, STOP.
// Each SCL bit is four quarters of CLK_DIV system clocks; SDA is open-drain.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_WRITE    = 3'd4,
        S_READ     = 3'd5,
        S_DATA_ACK = 3'd6,
        S_STOP     = 3'd7
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_addr_rw;
    logic [7:0]       r_wdata;
    logic             r_rw;
    logic [7:0]       r_rx;
    logic [7:0]       r_rdata;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_err;
    logic             r_scl;
    logic             r_sda_low;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [1:0]       w_q_nxt;
    logic [2:0]       w_bit_nxt;
    logic             w_qend;
    logic             w_cell_end;
    logic             w_sample;
    logic             w_accept;
    logic             w_finish;
    logic             w_scl_nxt;
    logic             w_sda_low_nxt;
    logic             w_sda_in;

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign w_sda_in = sda;
    assign scl      = r_scl;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ack_err  = r_ack_err;
    assign rdata    = r_rdata;

    assign w_qend     = (r_div == DIV_LAST);
    assign w_cell_end = w_qend && (r_q == 2'd3);
    // SDA is sampled on the edge that enters Q3 of a bit cell.
    assign w_sample   = w_qend && (r_q == 2'd2);

    // Next-state, quarter/bit counters and transfer handshake strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_qend ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
        w_q_nxt     = w_qend ? r_q + 2'd1 : r_q;
        w_bit_nxt   = r_bit;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_nxt = {DIV_W{1'b0}};
                w_q_nxt   = 2'd0;
                w_bit_nxt = 3'd0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_qend && (r_q == 2'd1)) begin
                    w_state_nxt = S_ADDR;
                    w_q_nxt     = 2'd0;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_ADDR, S_WRITE, S_READ: begin
                if (w_cell_end) begin
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            S_ADDR_ACK: begin
                // r_ack_err can only have been set by this address NACK.
                if (w_cell_end) begin
                    if (r_ack_err) begin
                        w_state_nxt = S_STOP;
                    end else if (r_rw) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_WRITE;
                    end
                end else begin
                    w_state_nxt = S_ADDR_ACK;
                end
            end
            S_DATA_ACK: begin
                if (w_cell_end) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_DATA_ACK;
                end
            end
            S_STOP: begin
                if (w_cell_end) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = {DIV_W{1'b0}};
                w_q_nxt     = 2'd0;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    // Bus pin values for the upcoming state/quarter, so SCL/SDA come straight from flops.
    always_comb begin
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b0;
            end
            S_START: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b1;
            end
            S_ADDR: begin
                w_scl_nxt     = w_q_nxt[1];
                w_sda_low_nxt = ~r_addr_rw[3'd7 - w_bit_nxt];
            end
            S_WRITE: begin
                w_scl_nxt     = w_q_nxt[1];
                w_sda_low_nxt = ~r_wdata[3'd7 - w_bit_nxt];
            end
            S_ADDR_ACK, S_READ, S_DATA_ACK: begin
                w_scl_nxt     = w_q_nxt[1];
                w_sda_low_nxt = 1'b0;
            end
            S_STOP: begin
                w_scl_nxt     = (w_q_nxt != 2'd0);
                w_sda_low_nxt = ~w_q_nxt[1];
            end
            default: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b0;
            end
        endcase
    end

    // Control state, counters and registered bus pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= {DIV_W{1'b0}};
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_q       <= w_q_nxt;
            r_bit     <= w_bit_nxt;
            r_scl     <= w_scl_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_done    <= w_finish;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    // Request latching and data-path capture of slave ACKs and read bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_rw <= 8'h00;
            r_wdata   <= 8'h00;
            r_rw      <= 1'b0;
            r_rx      <= 8'h00;
            r_rdata   <= 8'h00;
            r_ack_err <= 1'b0;
        end else if (w_accept) begin
            r_addr_rw <= {addr, rw};
            r_wdata   <= wdata;
            r_rw      <= rw;
            r_ack_err <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                S_ADDR_ACK: r_ack_err <= r_ack_err | w_sda_in;
                S_READ:     r_rx      <= {r_rx[6:0], w_sda_in};
                S_DATA_ACK: begin
                    if (r_rw) begin
                        r_rdata <= r_rx;
                    end else begin
                        r_ack_err <= r_ack_err | w_sda_in;
                    end
                end
                default: r_rx <= r_rx;
            endcase
        end else begin
            r_rx <= r_rx;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bus monitor, a simple slave at address 0x64,
// and a linear sequence of write/read/NACK/back-to-back/reset scenarios.
module tb_i2c_master;

    localparam int CLK_DIV = 4;
    localparam int T_FULL  = (2 + 18 * 4 + 4) * CLK_DIV;
    localparam int T_NACK  = (2 + 9 * 4 + 4) * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda;

    logic slv_low = 1'b0;
    pullup pu (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and slave state
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    logic bits[$];
    int   rise_t[$];
    int   n_start = 0;
    int   n_stop = 0;
    int   n_done = 0;
    int   falls = 0;
    logic slv_sel = 1'b0;
    logic slv_rd = 1'b0;
    logic [7:0] slv_byte = 8'hAA;

    always @(negedge clk) begin
        logic [7:0] a;
        int idx;
        if (p_scl && scl && (sda !== p_sda)) begin
            if (!sda) begin
                n_start++;
                falls = 0;
                slv_sel = 1'b0;
                slv_low = 1'b0;
            end else begin
                n_stop++;
            end
        end
        if (!p_scl && scl) begin
            rise_t.push_back(cyc);
            bits.push_back(sda);
        end
        if (p_scl && !scl) begin
            falls++;
            idx = falls - 1;
            slv_low = 1'b0;
            if (idx == 8 && bits.size() >= 8) begin
                for (int i = 0; i < 8; i++) a[7-i] = bits[bits.size()-8+i];
                slv_sel = (a[7:1] == 7'h64);
                slv_rd  = a[0];
                slv_low = slv_sel;
            end else if (slv_sel && slv_rd && idx >= 9 && idx <= 16) begin
                slv_low = ~slv_byte[16-idx];
            end else if (slv_sel && !slv_rd && idx == 17) begin
                slv_low = 1'b1;
            end
        end
        if (done) n_done++;
        p_scl = scl;
        p_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int b0, r0, s0, p0;

    function automatic logic [7:0] get_byte(input int off);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++)
            if (b0 + off + i < bits.size()) v[7-i] = bits[b0+off+i];
        return v;
    endfunction

    task automatic start_xfer(input logic [6:0] a, input logic r, input logic [7:0] d, input logic hold);
        @(negedge clk);
        addr = a; rw = r; wdata = d; start = 1'b1;
        b0 = bits.size(); r0 = rise_t.size(); s0 = n_start; p0 = n_stop;
        @(posedge clk);
        #1;
        chk("busy_after_accept", busy, 1'b1);
        start = hold;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic check_bus(input string tag, input int nrise);
        logic ok;
        ok = 1'b1;
        chk({tag, "_rises"}, rise_t.size() - r0, nrise);
        for (int i = r0 + 1; i < rise_t.size() - 1; i++)
            if (rise_t[i] - rise_t[i-1] != 4 * CLK_DIV) ok = 1'b0;
        if (rise_t.size() - r0 >= 2 && rise_t[rise_t.size()-1] - rise_t[rise_t.size()-2] != 3 * CLK_DIV) ok = 1'b0;
        chk({tag, "_scl_period"}, ok, 1'b1);
        chk({tag, "_starts"}, n_start - s0, 1);
        chk({tag, "_stops"}, n_stop - p0, 1);
    endtask

    int n;
    int d0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write 0xA5 to 0x64
        start_xfer(7'h64, 1'b0, 8'hA5, 1'b0);
        wait_done(n);
        chk("wr_latency", n, T_FULL);
        chk("wr_busy_low", busy, 1'b0);
        chk("wr_ack_err", ack_err, 1'b0);
        chk("wr_addr_byte", get_byte(0), 8'hC8);
        chk("wr_addr_ack", bits[b0+8], 1'b0);
        chk("wr_data_byte", get_byte(9), 8'hA5);
        chk("wr_data_ack", bits[b0+17], 1'b0);
        check_bus("wr", 19);
        @(posedge clk);
        #1;
        chk("wr_done_pulse", done, 1'b0);

        // Read from 0x64, slave returns 0xAA
        start_xfer(7'h64, 1'b1, 8'h00, 1'b0);
        wait_done(n);
        chk("rd_latency", n, T_FULL);
        chk("rd_rdata", rdata, 8'hAA);
        chk("rd_ack_err", ack_err, 1'b0);
        chk("rd_addr_byte", get_byte(0), 8'hC9);
        chk("rd_bus_byte", get_byte(9), 8'hAA);
        chk("rd_master_nack", bits[b0+17], 1'b1);
        check_bus("rd", 19);

        // Address NACK at 0x13
        start_xfer(7'h13, 1'b0, 8'h5A, 1'b0);
        wait_done(n);
        chk("nack_latency", n, T_NACK);
        chk("nack_ack_err", ack_err, 1'b1);
        chk("nack_bit", bits[b0+8], 1'b1);
        chk("nack_rdata_held", rdata, 8'hAA);
        check_bus("nack", 10);

        // start held high through a transfer and across done
        start_xfer(7'h64, 1'b0, 8'h3C, 1'b1);
        wait_done(n);
        chk("hold_latency", n, T_FULL);
        chk("hold_ack_err_cleared", ack_err, 1'b0);
        chk("hold_data_byte", get_byte(9), 8'h3C);
        check_bus("hold", 19);
        chk("hold_busy_at_done", busy, 1'b0);
        b0 = bits.size(); r0 = rise_t.size(); s0 = n_start; p0 = n_stop;
        @(posedge clk);
        #1;
        chk("hold_reaccept_busy", busy, 1'b1);
        start = 1'b0;
        wait_done(n);
        chk("hold2_latency", n, T_FULL);
        chk("hold2_data_byte", get_byte(9), 8'h3C);
        check_bus("hold2", 19);

        // Reset during WRITE bit 3
        start_xfer(7'h64, 1'b0, 8'hA5, 1'b0);
        repeat (205) @(posedge clk);
        #1;
        chk("mid_scl_low", scl, 1'b0);
        chk("mid_sda_bit3", sda, 1'b0);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("arst_scl", scl, 1'b1);
        chk("arst_sda", sda, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdata", rdata, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * T_FULL) @(posedge clk);
        #1;
        chk("arst_no_done", n_done - d0, 0);
        chk("arst_idle_busy", busy, 1'b0);

        // Normal transfer after reset
        start_xfer(7'h64, 1'b0, 8'h81, 1'b0);
        wait_done(n);
        chk("post_latency", n, T_FULL);
        chk("post_ack_err", ack_err, 1'b0);
        chk("post_data_byte", get_byte(9), 8'h81);
        check_bus("post", 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
